// File: rtl/operand_sequencer_if.sv
// Operand/result bus between the sequencer and the external 7-bit adder.
// The sequencer is the master: it drives operands and reads back the sum.
interface operand_sequencer_if;
    logic [6:0] A;
    logic [6:0] B;
    logic       C_in;
    logic [6:0] S;
    logic       C_out;

    modport master (output A, B, C_in, input S, C_out);
    modport slave  (input A, B, C_in, output S, C_out);
endinterface

// File: rtl/operand_sequencer.sv
// Button-driven sequencer that loads two operands from switches into an
// external adder, waits one settle cycle, and snapshots the sum.
module operand_sequencer (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                SW,
    input  logic                      CIN_SW,
    input  logic                      btn_load,
    input  logic                      btn_clear,
    operand_sequencer_if.master       adder,
    output logic [7:0]                result,
    output logic                      valid,
    output logic [1:0]                state,
    output logic [3:0]                op_count
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e     cur_state, nxt_state;
    logic [1:0] sync1, sync2, dly, armed, pulse;
    logic [1:0] settle_cnt;
    logic       settle_done;
    logic       load_pulse, clr_pulse;
    logic       cap_a, cap_b, cap_res, drop_valid, do_clear;
    logic [6:0] a_q, b_q;
    logic       cin_q;

    assign settle_done = (settle_cnt == 2'd2);

    // Bit 0 = load, bit 1 = clear. A button is armed only after it has been
    // seen low once the chain has flushed, so a press held through reset is ignored.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            dly        <= '0;
            armed      <= '0;
            settle_cnt <= '0;
        end else begin
            sync1 <= {btn_clear, btn_load};
            sync2 <= sync1;
            dly   <= sync2;
            if (!settle_done)
                settle_cnt <= settle_cnt + 2'd1;
            if (settle_done)
                armed <= armed | ~sync2;
        end
    end

    assign pulse      = sync2 & ~dly & armed;
    assign load_pulse = pulse[0];
    assign clr_pulse  = pulse[1];

    always_ff @(posedge clk) begin
        if (reset)
            cur_state <= LOAD_A;
        else
            cur_state <= nxt_state;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        nxt_state  = cur_state;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        cap_res    = 1'b0;
        drop_valid = 1'b0;
        do_clear   = 1'b0;
        if (clr_pulse) begin
            nxt_state = LOAD_A;
            do_clear  = 1'b1;
        end else begin
            case (cur_state)
                LOAD_A: if (load_pulse) begin
                    cap_a     = 1'b1;
                    nxt_state = LOAD_B;
                end
                LOAD_B: if (load_pulse) begin
                    cap_b     = 1'b1;
                    nxt_state = COMPUTE;
                end
                COMPUTE: begin
                    cap_res   = 1'b1;
                    nxt_state = DONE;
                end
                DONE: if (load_pulse) begin
                    drop_valid = 1'b1;
                    nxt_state  = LOAD_A;
                end
                default: nxt_state = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            result   <= '0;
            valid    <= 1'b0;
            op_count <= '0;
        end else if (do_clear) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            result <= '0;
            valid  <= 1'b0;
        end else begin
            if (cap_a)
                a_q <= SW;
            if (cap_b) begin
                b_q   <= SW;
                cin_q <= CIN_SW;
            end
            if (cap_res) begin
                result <= {adder.C_out, adder.S};
                valid  <= 1'b1;
                if (op_count != 4'd15)
                    op_count <= op_count + 4'd1;
            end
            if (drop_valid)
                valid <= 1'b0;
        end
    end

    assign adder.A    = a_q;
    assign adder.B    = b_q;
    assign adder.C_in = cin_q;
    assign state      = cur_state;

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 The block SHALL have no parameters; all datapath widths are fixed at 7 bits, matching the downstream 7-bit adder.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 SW  input  7  operand value from the board switches.
REQ-005 CIN_SW  input  1  carry-in value, captured together with operand B.
REQ-006 btn_load  input  1  asynchronous raw push-button that advances the sequence.
REQ-007 btn_clear  input  1  asynchronous raw push-button that aborts to the start of the sequence.
REQ-008 A  output  7  registered operand A, driven to the adder.
REQ-009 B  output  7  registered operand B, driven to the adder.
REQ-010 C_in  output  1  registered carry-in, driven to the adder.
REQ-011 S  input  7  sum returned by the adder.
REQ-012 C_out  input  1  carry-out returned by the adder.
REQ-013 result  output  8  registered {C_out, S} snapshot.
REQ-014 valid  output  1  result holds a completed addition for the current operands.
REQ-015 state  output  2  current FSM state code.
REQ-016 op_count  output  4  number of completed additions, saturating.

Function
REQ-017 btn_load and btn_clear SHALL each pass through a 2-flop synchronizer plus a delay flop; the derived pulse is sync2 AND NOT delayed.
REQ-018 A button SHALL act on the third rising clk edge after it is first sampled high, and SHALL act exactly once per press regardless of hold length.
REQ-019 FSM state codes SHALL be: LOAD_A=0, LOAD_B=1, COMPUTE=2, DONE=3.
REQ-020 In LOAD_A, a load pulse SHALL capture A<=SW and move to LOAD_B.
REQ-021 In LOAD_B, a load pulse SHALL capture B<=SW and C_in<=CIN_SW, and move to COMPUTE.
REQ-022 COMPUTE SHALL last exactly one cycle, which is the settle window of the combinational adder; load pulses during this cycle SHALL be ignored.
REQ-023 On the COMPUTE->DONE transition, the block SHALL capture result<={C_out,S}, set valid<=1, and increment op_count if op_count<15.
REQ-024 In DONE, a load pulse SHALL move to LOAD_A and clear valid; result SHALL hold until the next capture.
REQ-025 A clear pulse in any state SHALL force LOAD_A, zero A, B, C_in and result, and clear valid; op_count SHALL be unchanged.
REQ-026 When clear and load pulses occur in the same cycle, clear SHALL win and load SHALL be dropped.
REQ-027 The SW and CIN_SW inputs SHALL be sampled only on capture edges; changes at any other time SHALL NOT affect A, B or C_in.
REQ-028 op_count SHALL hold at 15 after the 15th addition, with no wrap to 0.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from S or C_out to result.

Reset
REQ-030 While reset=1 at a clk edge: state=LOAD_A, A=B=0, C_in=0, result=0, valid=0, op_count=0, and all synchronizer flops=0.
REQ-031 Reset SHALL override clear and load, and SHALL abort any state, including COMPUTE, without capturing result.
REQ-032 A button already held high when reset deasserts SHALL NOT generate a pulse until it is released and pressed again.

Verification
REQ-033 SW=45, load; SW=27, CIN_SW=1, load -> one COMPUTE cycle, then result=8'h49, valid=1, op_count=1, state=3.
REQ-034 A=127, B=1, C_in=0 -> result=8'h80 (carry set). A=127, B=127, C_in=1 -> result=8'hFF.
REQ-035 btn_load held high for 50 cycles in LOAD_A -> exactly one capture; state=1 and remains 1.
REQ-036 Clear pressed in LOAD_B after A=9 was loaded -> state=0, A=0, valid=0, op_count unchanged. Clear and load pulses aligned in the same cycle -> clear behaviour only.
REQ-037 Reset asserted during COMPUTE -> all outputs zero on the next edge and result not updated. 16 back-to-back additions -> op_count=15.
